// File: rtl/fspeed_req_sched.sv
// Request scheduler in front of the fspeed ramp: arbitrates NREQ requesters to
// the highest level, paces requested_speed one level per STEP_CYCLES, holds off
// decreases for HOLD_CYCLES after an increase, and offers a force-off path.
module fspeed_req_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned MAX_SPEED   = 4,
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_speed,
  input  logic              force_off,
  input  logic [4:0]        cur_speed,
  output logic [4:0]        requested_speed,
  output logic [2:0]        owner,
  output logic              owner_valid,
  output logic [2:0]        state,
  output logic              settled
);

  localparam int unsigned SW = (STEP_CYCLES < 3) ? 1 : $clog2(STEP_CYCLES);
  localparam int unsigned HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP     = 3'd1,
    HOLD   = 3'd2,
    DOWN   = 3'd3,
    STEADY = 3'd4,
    FORCED = 3'd5
  } state_t;

  state_t        st_q, st_n;
  logic [2:0]    goal_q;
  logic [SW-1:0] step_cnt, step_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [4:0]    req_n;
  logic [2:0]    arb_goal, arb_owner, lvl;
  logic          arb_found;
  logic [4:0]    goal_w, arb_goal_w;

  assign goal_w     = {2'b00, goal_q};
  assign arb_goal_w = {2'b00, arb_goal};
  assign state      = st_q;

  // Clamp each request and pick the highest level; lowest index wins ties.
  always_comb begin
    arb_goal  = 3'd0;
    arb_owner = owner;
    arb_found = 1'b0;
    lvl       = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      lvl = req_speed[3*i +: 3];
      if (lvl > 3'(MAX_SPEED)) lvl = 3'(MAX_SPEED);
      if (req_valid[i] && (!arb_found || (lvl > arb_goal))) begin
        arb_goal  = lvl;
        arb_owner = 3'(i);
        arb_found = 1'b1;
      end
    end
  end

  // Pacing, hold-off and state classification from the post-update values.
  always_comb begin
    req_n  = requested_speed;
    step_n = (step_cnt != '0) ? step_cnt - SW'(1) : '0;
    hold_n = (hold_cnt != '0) ? hold_cnt - HW'(1) : '0;
    st_n   = st_q;
    if (force_off) begin
      req_n  = 5'd0;
      step_n = '0;
      hold_n = '0;
    end else if (step_cnt == '0) begin
      if (goal_w > requested_speed) begin
        req_n  = requested_speed + 5'd1;
        step_n = SW'(STEP_CYCLES - 1);
        hold_n = HW'(HOLD_CYCLES);
      end else if ((goal_w < requested_speed) && (hold_cnt == '0)) begin
        req_n  = requested_speed - 5'd1;
        step_n = SW'(STEP_CYCLES - 1);
      end
    end
    if (force_off)                                st_n = FORCED;
    else if ((req_n == 5'd0) && (arb_goal == 3'd0)) st_n = IDLE;
    else if (arb_goal_w > req_n)                   st_n = UP;
    else if (arb_goal_w < req_n)                   st_n = (hold_n != '0) ? HOLD : DOWN;
    else                                           st_n = STEADY;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q            <= IDLE;
      requested_speed <= 5'd0;
      goal_q          <= 3'd0;
      owner           <= 3'd0;
      owner_valid     <= 1'b0;
      step_cnt        <= '0;
      hold_cnt        <= '0;
    end else begin
      st_q            <= st_n;
      requested_speed <= req_n;
      goal_q          <= arb_goal;
      owner           <= arb_owner;
      owner_valid     <= arb_found;
      step_cnt        <= step_n;
      hold_cnt        <= hold_n;
    end
  end

  // Target matched and the downstream ramp has caught up.
  assign settled = (requested_speed == goal_w) && (cur_speed == requested_speed) &&
                   (st_q != FORCED);

endmodule

// File: doc/fspeed_req_sched.md
Name: fspeed_req_sched

Overview:
- Shares the single speed-ramp datapath (the `fspeed` block: 5-bit `requested_speed` in, 5-bit current speed out, steps ±1 per clock toward the request) between NREQ requesters.
- Arbitrates to the highest requested level and paces the ramp one level per STEP_CYCLES.
- Enforces a minimum hold time after any increase before stepping down.
- Provides an emergency force-off path.
- Sits directly upstream of `fspeed` and drives its `requested_speed` input.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_SPEED, 4, highest legal level; must be ≤4 because the downstream ramp ignores requests ≥5.
- STEP_CYCLES, 4, minimum cycles between successive changes of `requested_speed` (≥1).
- HOLD_CYCLES, 16, cycles after the last increase during which no decrease is allowed (≥0).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request-active flag.
- req_speed  input  3*NREQ  packed requested levels; requester i uses bits [3i+2:3i].
- force_off  input  1  emergency off, level-sensitive.
- cur_speed  input  5  current speed fed back from the ramp block.
- requested_speed  output  5  registered target driven to the ramp block.
- owner  output  3  index of the winning requester.
- owner_valid  output  1  at least one request was active in the last sampled cycle.
- state  output  3  FSM state encoding.
- settled  output  1  target reached and ramp has caught up.

Behaviour:
- Reset (clk edge with reset=1) clears the following registers:
  - requested_speed=0, goal_q=0, owner=0, owner_valid=0.
  - step_cnt=0, hold_cnt=0, state=IDLE(0).
  - reset has priority over force_off and all other inputs.
- Clamp: each req_speed value greater than MAX_SPEED is treated as MAX_SPEED.
- Arbitration (registered each cycle into goal_q/owner/owner_valid):
  - goal = maximum clamped level among requesters with req_valid=1.
  - Ties go to the lowest index.
  - No valid requester: goal=0, owner holds its previous value, owner_valid=0.
- Pacing:
  - step_cnt decrements each cycle, saturating at 0. A step is allowed only when step_cnt==0.
  - Up step: if goal_q > requested_speed, increment requested_speed by 1, reload step_cnt=STEP_CYCLES-1, load hold_cnt=HOLD_CYCLES.
  - Down step: else if goal_q < requested_speed and hold_cnt==0, decrement by 1 and reload step_cnt.
  - hold_cnt decrements each cycle, saturating at 0.
- Latency:
  - A request change sampled at edge n appears in goal_q at edge n.
  - The earliest requested_speed change is at edge n+1.
- force_off=1 (sampled):
  - Next edge: requested_speed=0, step_cnt=0, hold_cnt=0, state=FORCED. This bypasses pacing and hold.
  - Arbitration keeps updating goal_q/owner.
  - On deassertion, normal pacing resumes from 0 with step_cnt=0, so the first up-step is immediate.
- States, re-evaluated every edge from post-update registers (A = requested_speed after the update, G = goal_q):
  - IDLE(0): A==0 and G==0.
  - UP(1): G>A.
  - HOLD(2): G<A and hold_cnt>0.
  - DOWN(3): G<A and hold_cnt==0.
  - STEADY(4): A==G≠0.
  - FORCED(5): force_off was sampled high.
- settled (combinational) = (requested_speed==goal_q) && (cur_speed==requested_speed) && state≠FORCED. Its value is 1 out of reset when cur_speed==0.
- Widths:
  - requested_speed bits [4:3] are always 0.
  - The value never exceeds MAX_SPEED and never underflows below 0.
- Goal changes mid-ramp take effect at the next step tick; pacing does not restart.
  - Example: at requested_speed=2 while ramping to 4, the goal drops to 1. requested_speed stays at 2 until hold_cnt expires, then steps down.

Test Plan:
- Start-up and single requester:
  - Stimulus: reset 2 cycles, then req0 valid with speed 3 (STEP_CYCLES=4).
  - Response: requested_speed becomes 1, 2, 3 at edges 1, 5, 9 after goal_q=3; owner=0, owner_valid=1; state UP then STEADY.
  - Response: settled=1 once cur_speed=3.
- Arbitration:
  - Stimulus: req1=2 and req3=4 valid.
  - Response: owner=3, goal 4.
  - Stimulus: then req0=4 added.
  - Response: owner=0, goal still 4; requested_speed sequence unaffected.
- Hold then ramp down:
  - Stimulus: request reaches 3, then is dropped to 1 one cycle after the last increase.
  - Response: state HOLD; requested_speed stays 3 until 16 cycles after the increase, then steps 2, 1 spaced 4 cycles apart; state DOWN, then STEADY.
- Clamp and no-requesters:
  - Stimulus: req2 valid with speed 7.
  - Response: goal_q=4, requested_speed saturates at 4 and never reaches 5.
  - Stimulus: all req_valid=0.
  - Response: owner_valid=0 and the ramp returns to 0 after the hold expires; state IDLE.
- Force-off mid-ramp:
  - Stimulus: force_off asserted at requested_speed=3.
  - Response: next edge requested_speed=0, state FORCED, settled=0.
  - Stimulus: release force_off with req0=2 active.
  - Response: requested_speed=1 on the first edge after release, 2 four cycles later.
- Reset mid-operation:
  - Stimulus: reset asserted during UP at requested_speed=2 with force_off=1.
  - Response: all outputs take their reset values on the next edge; state IDLE.
